prog_loader: RTL

- Upstream stage of the 8-bit multicycle CPU.
- Accepts a framed byte stream over a valid/ready handshake and writes it into the CPU's 256x8 memory through the memory write port.
- Checks an 8-bit additive checksum, then releases the CPU from hold.
- The top level muxes the memory address/data/wren between this block (while cpu_hold=1) and the CPU datapath.

---
 rtl/prog_loader.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: upstream loader stage for the 8-bit multicycle CPU.
// Receives a framed byte stream over valid/ready, writes the payload into the
// CPU memory write port, checks an 8-bit additive checksum and then releases
// the CPU from hold. Frame layout: LEN (0 means 256), LEN payload bytes, CSUM.
// Optional feature macro: PROG_LOADER_VERIFY_EN adds a readback verify pass
// that re-reads the payload region and re-checks the checksum before DONE.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [7:0]        mem_q,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [8:0]        byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
`ifdef PROG_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_ERROR
  } state_t;

  state_t            state_q, state_d;

  // Frame bookkeeping
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic [8:0]        cnt_q, cnt_d;

  // Registered memory-port and status outputs
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Derived frame conditions
  logic              xfer;
  logic [8:0]        len_eff;
  logic              last_data;
  logic              csum_ok;
  logic              enter_len;

`ifdef PROG_LOADER_VERIFY_EN
  // Readback verify state
  logic              rden_q, rden_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [8:0]        rd_cnt_q, rd_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        rb_sum_q, rb_sum_d;
  logic [8:0]        acc_cnt_q, acc_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        rb_next;
  logic              last_acc;
`endif

  // A byte moves only when the registered ready meets the source valid.
  assign xfer      = in_valid & rdy_q;
  // A length byte of zero stands for a full 256-byte page.
  assign len_eff   = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  assign last_data = ((cnt_q + 9'd1) == len_eff);
  assign csum_ok   = (in_data == sum_q);

`ifdef PROG_LOADER_VERIFY_EN
  // mem_q carries the read issued two edges ago; rd_vld_q marks it valid.
  assign rb_next  = rb_sum_q + mem_q;
  assign last_acc = ((acc_cnt_q + 9'd1) == len_eff);
`endif

  // State register and all registered datapath/output state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= 8'd0;
      addr_q    <= BASE_ADDR;
      sum_q     <= 8'd0;
      cnt_q     <= 9'd0;
      wren_q    <= 1'b0;
      maddr_q   <= BASE_ADDR;
      wdata_q   <= 8'd0;
      rdy_q     <= 1'b0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      rden_q    <= 1'b0;
      rd_addr_q <= BASE_ADDR;
      rd_cnt_q  <= 9'd0;
      rd_vld_q  <= 1'b0;
      rb_sum_q  <= 8'd0;
      acc_cnt_q <= 9'd0;
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      wren_q    <= wren_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PROG_LOADER_VERIFY_EN
      rden_q    <= rden_d;
      rd_addr_q <= rd_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      rb_sum_q  <= rb_sum_d;
      acc_cnt_q <= acc_cnt_d;
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state logic: frame sequencing; start only restarts from a rest state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer && last_data) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) begin
`ifdef PROG_LOADER_VERIFY_EN
          state_d = csum_ok ? S_VERIFY : S_ERROR;
`else
          state_d = csum_ok ? S_DONE : S_ERROR;
`endif
        end
      end
`ifdef PROG_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (rd_vld_q && last_acc) state_d = (rb_next == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: next values of every registered output and counter.
  always_comb begin
    len_d     = len_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    wren_d    = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    enter_len = (state_d == S_LEN) && (state_q != S_LEN);
    rdy_d     = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERROR);
    hold_d    = (state_d != S_DONE);
`ifdef PROG_LOADER_VERIFY_EN
    rden_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    rd_vld_d  = rden_q;
    rb_sum_d  = rb_sum_q;
    acc_cnt_d = acc_cnt_q;
    csum_d    = csum_q;
`endif

    // A new frame starts from a clean slate at the base address.
    if (enter_len) begin
      sum_d  = 8'd0;
      cnt_d  = 9'd0;
      addr_d = BASE_ADDR;
    end

    if ((state_q == S_LEN) && xfer) begin
      len_d = in_data;
    end

    // Each payload byte becomes a one-cycle write in the following cycle.
    if ((state_q == S_DATA) && xfer) begin
      wren_d  = 1'b1;
      maddr_d = addr_q;
      wdata_d = in_data;
      sum_d   = sum_q + in_data;
      addr_d  = addr_q + 1'b1;
      cnt_d   = cnt_q + 9'd1;
    end

`ifdef PROG_LOADER_VERIFY_EN
    // Checksum accepted: issue the first readback in the same edge.
    if ((state_q == S_CSUM) && xfer) begin
      csum_d = in_data;
      if (state_d == S_VERIFY) begin
        rden_d    = 1'b1;
        maddr_d   = BASE_ADDR;
        rd_addr_d = BASE_ADDR + 1'b1;
        rd_cnt_d  = 9'd1;
        rb_sum_d  = 8'd0;
        acc_cnt_d = 9'd0;
      end
    end

    // One read per cycle until len reads are out; sum data as it returns.
    if (state_q == S_VERIFY) begin
      if (rd_cnt_q != len_eff) begin
        rden_d    = 1'b1;
        maddr_d   = rd_addr_q;
        rd_addr_d = rd_addr_q + 1'b1;
        rd_cnt_d  = rd_cnt_q + 9'd1;
      end
      if (rd_vld_q) begin
        rb_sum_d  = rb_next;
        acc_cnt_d = acc_cnt_q + 9'd1;
      end
    end
`endif
  end

  assign in_ready   = rdy_q;
  assign mem_addr   = maddr_q;
  assign mem_data   = wdata_q;
  assign mem_wren   = wren_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;
  assign byte_count = cnt_q;

`ifdef PROG_LOADER_VERIFY_EN
  assign mem_rden = rden_q;
`else
  // Without verify the read port is idle and its data is intentionally ignored.
  logic [7:0] unused_mem_q;
  assign unused_mem_q = mem_q;
  assign mem_rden     = 1'b0;
`endif

endmodule
